pcs_am_lock_rx: RTL

Per-PCS-lane alignment marker lock receiver for the 40G/100G BASE-R receive path, following the IEEE 802.3 Clause 82 AM lock state machine. It sits after block lock and descrambler bypass, and ahead of lane deskew and reorder.
- Watches 66-bit blocks on one physical lane.
- Identifies which PCS lane's marker is present and achieves marker lock.
- Tracks lock loss and pulses an am-position strobe for the deskew logic.
- Parametrised in lane count (4 or 20), marker gap and invalid-count threshold.

---
 rtl/pcs_am_pkg.sv | 27 ++
 rtl/pcs_am_lane_match.sv | 40 ++++
 rtl/pcs_am_lock_rx.sv | 110 +++++++++++
 3 files changed

// File: rtl/pcs_am_pkg.sv
// pcs_am_pkg: alignment marker tables, sync header constant and AM lock state enum
//   am_marker(lane, lane_n) returns {M2,M1,M0}, laid out as block[25:2] of a received block
package pcs_am_pkg;

    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {FIND_1ST, COUNT_1, LOCKED} am_state_t;

    // Entries are written M0,M1,M2 from MSB to LSB so they read like the marker tables
    localparam logic [23:0] AM_40G [4] = '{
        24'h907647, 24'hF0C4E6, 24'hC5659B, 24'hA2793D
    };

    localparam logic [23:0] AM_100G [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    function automatic logic [23:0] am_marker(input int lane, input int lane_n);
        logic [23:0] m;
        m = (lane_n == 20) ? AM_100G[lane[4:0]] : AM_40G[lane[1:0]];
        return {m[7:0], m[15:8], m[23:16]};
    endfunction

endpackage

// File: rtl/pcs_am_lane_match.sv
// pcs_am_lane_match: combinational alignment marker detector for one 66-bit block
//   block : received block, [1:0] sync header, [9:2] M0 ... [65:58] M7
//   hit   : block is a marker of some PCS lane (M3/M7 BIP bytes ignored)
//   lane  : index of the matching lane, lowest wins
module pcs_am_lane_match
    import pcs_am_pkg::*;
#(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int LANE_W  = $clog2(LANE_N)
) (
    input  logic [BLOCK_W-1:0] block,
    output logic               hit,
    output logic [LANE_W-1:0]  lane
);

    if (LANE_N != 4 && LANE_N != 20) begin : g_bad_lane_n
        $error("pcs_am_lane_match: LANE_N must be 4 or 20");
    end

    logic form_ok;
    logic unused_bip;

    // M4..M6 must be the bitwise inverse of M0..M2
    assign form_ok    = block[1:0] == SYNC_CTRL && block[57:34] == ~block[25:2];
    assign unused_bip = ^{block[BLOCK_W-1:58], block[33:26]};

    // Scan downwards so the lowest matching lane is the one left in lane
    always_comb begin
        hit  = 1'b0;
        lane = '0;
        for (int l = LANE_N - 1; l >= 0; l--) begin
            if (form_ok && block[25:2] == am_marker(l, LANE_N)) begin
                hit  = 1'b1;
                lane = l[LANE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcs_am_lock_rx.sv
// pcs_am_lock_rx: per-lane alignment marker lock receiver (40G/100G BASE-R AM lock)
//   clk, reset      : clock, synchronous active-high reset
//   valid_i/block_i : incoming 66-bit block and its qualifier
//   slip_v_o        : pulse, marker search restarted
//   lock_v_o        : marker lock achieved
//   lane_o          : PCS lane of the marker being tracked
//   am_v_o          : pulse, expected marker position seen while locked
module pcs_am_lock_rx
    import pcs_am_pkg::*;
#(
    parameter int BLOCK_W  = 66,
    parameter int LANE_N   = 4,
    parameter int GAP_N    = 16383,
    parameter int NV_CNT_N = 4,
    parameter int LANE_W   = $clog2(LANE_N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               slip_v_o,
    output logic               lock_v_o,
    output logic [LANE_W-1:0]  lane_o,
    output logic               am_v_o
);

    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam int NV_W  = $clog2(NV_CNT_N + 1);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(GAP_N);
    localparam logic [NV_W-1:0]  NV_MAX  = NV_W'(NV_CNT_N);

    am_state_t         state;
    logic [CNT_W-1:0]  gap_q;
    logic [NV_W-1:0]   nv_q;
    logic              m_hit;
    logic [LANE_W-1:0] m_lane;
    logic              good;

    pcs_am_lane_match #(
        .BLOCK_W (BLOCK_W),
        .LANE_N  (LANE_N),
        .LANE_W  (LANE_W)
    ) u_match (
        .block (block_i),
        .hit   (m_hit),
        .lane  (m_lane)
    );

    // A marker only counts at the candidate if it belongs to the lane found first
    assign good = m_hit && m_lane == lane_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FIND_1ST;
            gap_q    <= '0;
            nv_q     <= '0;
            lane_o   <= '0;
            lock_v_o <= 1'b0;
            slip_v_o <= 1'b0;
            am_v_o   <= 1'b0;
        end else begin
            slip_v_o <= 1'b0;
            am_v_o   <= 1'b0;
            if (valid_i) begin
                case (state)
                    FIND_1ST: begin
                        if (m_hit) begin
                            lane_o <= m_lane;
                            gap_q  <= '0;
                            state  <= COUNT_1;
                        end
                    end
                    COUNT_1: begin
                        gap_q <= (gap_q == GAP_MAX) ? '0 : gap_q + 1'b1;
                        if (gap_q == GAP_MAX) begin
                            if (good) begin
                                state    <= LOCKED;
                                lock_v_o <= 1'b1;
                                nv_q     <= '0;
                                am_v_o   <= 1'b1;
                            end else begin
                                slip_v_o <= 1'b1;
                                state    <= FIND_1ST;
                            end
                        end
                    end
                    LOCKED: begin
                        gap_q <= (gap_q == GAP_MAX) ? '0 : gap_q + 1'b1;
                        if (gap_q == GAP_MAX) begin
                            if (good) begin
                                nv_q   <= '0;
                                am_v_o <= 1'b1;
                            end else if (nv_q + 1'b1 == NV_MAX) begin
                                nv_q     <= '0;
                                lock_v_o <= 1'b0;
                                slip_v_o <= 1'b1;
                                state    <= FIND_1ST;
                            end else begin
                                nv_q   <= nv_q + 1'b1;
                                am_v_o <= 1'b1;
                            end
                        end
                    end
                    default: state <= FIND_1ST;
                endcase
            end
        end
    end

endmodule
